// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared CPU constants: bubble word, opcodes, fetch FSM states.
// Revision    : 1.0
// ============================================================================
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [4:0] {
        OP_ALU  = 5'd0,
        OP_J    = 5'd1,
        OP_BNE  = 5'd2,
        OP_JAL  = 5'd3,
        OP_JR   = 5'd4,
        OP_ADDI = 5'd5,
        OP_BLT  = 5'd6,
        OP_SW   = 5'd7,
        OP_LW   = 5'd8,
        OP_BEX  = 5'd22
    } opcode_e;

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_fd_latch.sv
`default_nettype none
// ============================================================================
// Module      : fd_latch
// Description : F/D pipeline register; clear loads a bubble and dominates load.
// Revision    : 1.0
// ============================================================================
module fd_latch #(
    parameter logic [31:0] NOP = 32'h0000_0000
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic        enable_i,
    input  logic        clear_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        valid_q;

    // A bubble keeps the previous PC+1 so decode still sees a sane link value.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            instr_q <= NOP;
            pc_q    <= 32'd0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (enable_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : PC register, fetch FSM and fetch counter feeding the F/D latch.
// Revision    : 1.0
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = fetch_stage_pkg::NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fd_instr,
    output logic [31:0] fd_pc,
    output logic        fd_valid,
    output logic [31:0] fetch_count
);

    import fetch_stage_pkg::ST_BOOT;
    import fetch_stage_pkg::ST_RUN;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus1;
    logic        latch_en;
    logic        latch_clr;

    assign pc_plus1 = pc_q + 32'd1;

    // Priority in RUN: redirect, then stall, then fetch/bubble.
    always_comb begin
        state_d   = ST_RUN;
        pc_d      = pc_q;
        count_d   = count_q;
        latch_en  = 1'b0;
        latch_clr = 1'b0;
        case (state_q)
            ST_BOOT: begin
                latch_clr = 1'b1;
                if (redirect) begin
                    pc_d = redirect_pc;
                end
            end
            default: begin
                if (redirect) begin
                    pc_d      = redirect_pc;
                    latch_clr = 1'b1;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (imem_ready) begin
                    pc_d     = pc_plus1;
                    count_d  = count_q + 32'd1;
                    latch_en = 1'b1;
                end else begin
                    latch_clr = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    fd_latch #(
        .NOP (NOP)
    ) u_fd_latch (
        .clock_i  (clock),
        .reset_ni (reset),
        .enable_i (latch_en),
        .clear_i  (latch_clr),
        .instr_i  (imem_data),
        .pc_i     (pc_plus1),
        .instr_o  (fd_instr),
        .pc_o     (fd_pc),
        .valid_o  (fd_valid)
    );

    assign imem_addr   = pc_q;
    assign fetch_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage.
// Revision    : 1.0
// ============================================================================
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] fd_instr;
    logic [31:0] fd_pc;
    logic        fd_valid;
    logic [31:0] fetch_count;

    int n_pass  = 0;
    int n_total = 0;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP      (32'h0000_0000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .imem_ready  (imem_ready),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fd_instr    (fd_instr),
        .fd_pc       (fd_pc),
        .fd_valid    (fd_valid),
        .fetch_count (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_addr, input logic [31:0] e_instr,
                             input logic [31:0] e_pc, input logic e_valid, input logic [31:0] e_cnt);
        check({tag, ".addr"},  imem_addr, e_addr);
        check({tag, ".instr"}, fd_instr, e_instr);
        check({tag, ".fdpc"},  fd_pc, e_pc);
        check({tag, ".valid"}, {31'd0, fd_valid}, {31'd0, e_valid});
        check({tag, ".count"}, fetch_count, e_cnt);
    endtask

    initial begin
        reset       = 1'b0;
        imem_ready  = 1'b1;
        imem_data   = 32'h2820_0005;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        step();
        step();
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

        // Release between edges; the first edge is the BOOT cycle.
        reset = 1'b1;
        step();
        check_all("boot", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        step();
        check_all("fetch0", 32'h1, 32'h2820_0005, 32'h1, 1'b1, 32'd1);

        imem_data = 32'hAAAA_0001;
        stall     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all($sformatf("stall%0d", i), 32'h1, 32'h2820_0005, 32'h1, 1'b1, 32'd1);
        end
        stall = 1'b0;
        step();
        check_all("fetch1", 32'h2, 32'hAAAA_0001, 32'h2, 1'b1, 32'd2);

        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        stall       = 1'b1;
        imem_data   = 32'hBBBB_0002;
        step();
        check_all("redir_stall", 32'h40, 32'h0, 32'h2, 1'b0, 32'd2);

        redirect   = 1'b0;
        stall      = 1'b0;
        imem_ready = 1'b0;
        step();
        check_all("wait0", 32'h40, 32'h0, 32'h2, 1'b0, 32'd2);
        step();
        check_all("wait1", 32'h40, 32'h0, 32'h2, 1'b0, 32'd2);
        imem_ready = 1'b1;
        imem_data  = 32'hCCCC_0040;
        step();
        check_all("resume", 32'h41, 32'hCCCC_0040, 32'h41, 1'b1, 32'd3);

        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        check_all("redirA", 32'h100, 32'h0, 32'h41, 1'b0, 32'd3);
        redirect_pc = 32'h0000_0200;
        step();
        check_all("redirB", 32'h200, 32'h0, 32'h41, 1'b0, 32'd3);
        redirect  = 1'b0;
        imem_data = 32'hDDDD_0200;
        step();
        check_all("fetch_tgt", 32'h201, 32'hDDDD_0200, 32'h201, 1'b1, 32'd4);

        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        check_all("redir_max", 32'hFFFF_FFFF, 32'h0, 32'h201, 1'b0, 32'd4);
        redirect  = 1'b0;
        imem_data = 32'hEEEE_FFFF;
        step();
        check_all("wrap", 32'h0, 32'hEEEE_FFFF, 32'h0, 1'b1, 32'd5);

        imem_data = 32'h1111_0000;
        step();
        check_all("pre_rst", 32'h1, 32'h1111_0000, 32'h1, 1'b1, 32'd6);

        // Asynchronous reset asserted mid-cycle must act without a clock edge.
        #2;
        reset = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        step();
        check_all("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

        // Redirect is honoured during BOOT while ready is ignored.
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0080;
        imem_data   = 32'h1234_5678;
        step();
        check_all("boot_redir", 32'h80, 32'h0, 32'h0, 1'b0, 32'd0);
        redirect = 1'b0;
        step();
        check_all("boot_fetch", 32'h81, 32'h1234_5678, 32'h81, 1'b1, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and F/D pipeline latch of the five-stage CPU. Holds the program counter, drives the instruction-memory address, and captures each returned instruction with its PC+1 into the F/D latch consumed by decode-stage control. Accepts stall requests from the hazard logic and taken-branch/jump redirects from execute, and inserts NOP bubbles where required.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP`, 32'h0000_0000, instruction word inserted as a bubble (`add $0,$0,$0`).

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserting low clears all state immediately.
- `imem_addr`  out  32  fetch address, equal to the current PC register (combinational from the register).
- `imem_data`  in  32  instruction word for `imem_addr`; sampled only when `imem_ready`=1.
- `imem_ready`  in  1  `imem_data` is valid this cycle.
- `stall`  in  1  hold PC and F/D latch (decode hazard).
- `redirect`  in  1  taken branch/jump/jr/bex resolved in execute.
- `redirect_pc`  in  32  target PC when `redirect`=1.
- `fd_instr`  out  32  latched instruction to decode.
- `fd_pc`  out  32  PC+1 of `fd_instr`.
- `fd_valid`  out  1  `fd_instr` is a real fetched instruction (0 = bubble).
- `fetch_count`  out  32  count of instructions latched since reset.

## Operation
- FSM states: BOOT, RUN. Reset enters BOOT. BOOT lasts exactly one cycle, then RUN unconditionally.
- In BOOT: `stall` and `imem_ready` ignored; F/D latch holds NOP; `redirect` honoured (PC ← `redirect_pc`).
- In RUN, per cycle, priority redirect > stall > fetch:
  - `redirect`=1: PC ← `redirect_pc`; `fd_instr` ← NOP; `fd_valid` ← 0; `fd_pc` held; counter unchanged. Any pending memory wait is abandoned.
  - `stall`=1 (no redirect): PC, `fd_instr`, `fd_pc`, `fd_valid`, counter all held, even if `imem_ready`=1.
  - `imem_ready`=1: `fd_instr` ← `imem_data`; `fd_pc` ← PC+1; `fd_valid` ← 1; PC ← PC+1; `fetch_count` ← `fetch_count`+1.
  - `imem_ready`=0: PC held; `fd_instr` ← NOP; `fd_valid` ← 0 (bubble); counter unchanged.
- Arithmetic: PC+1 is 32-bit modulo; 32'hFFFF_FFFF+1 = 0. `fetch_count` wraps modulo 2^32.
- `fd_pc` stores PC+1 (not PC) so downstream branch-target and jal link computations use it directly.

## Timing
- Reset values: PC=`RESET_PC`, `imem_addr`=`RESET_PC`, `fd_instr`=NOP, `fd_pc`=0, `fd_valid`=0, `fetch_count`=0, state=BOOT.
- Fetch latency: word accepted with `imem_ready` in cycle n appears on `fd_instr` in cycle n+1; `imem_addr` advances in cycle n+1.
- Redirect: target on `imem_addr` the cycle after `redirect`; earliest target instruction on `fd_instr` two cycles after `redirect`.
- Stall has no latency: the F/D outputs visible during the stall cycle remain visible in the next cycle.
- Reset asserted mid-operation: all registers return to reset values asynchronously; in-flight instruction discarded.
- Back-to-back redirects: each applied in turn; only the last target is fetched.

## Structure
- Shared CPU package: `NOP` word, opcode constants (ALU=0, J=1, BNE=2, JAL=3, JR=4, ADDI=5, BLT=6, SW=7, LW=8, BEX=22), FSM state encoding.
- One sub-module `fd_latch`: 32-bit instr, 32-bit pc, valid bit, with `enable` (load) and `clear` (load NOP/valid=0) inputs; clear dominates enable. PC register, FSM and counter live in `fetch_stage`.

## Test plan
- Reset release with `imem_ready`=1, data 32'h2820_0005 at addr 0 -> BOOT cycle shows NOP; next edge `fd_instr`=32'h2820_0005, `fd_pc`=1, `fd_valid`=1, `fetch_count`=1.
- `stall`=1 for 3 cycles with `imem_ready`=1 -> `imem_addr`, `fd_instr`, `fd_pc`, `fetch_count` unchanged for all 3 cycles.
- `redirect`=1, `redirect_pc`=32'h0000_0040, together with `stall`=1 -> next cycle `imem_addr`=0x40, `fd_valid`=0, `fd_instr`=NOP.
- `imem_ready` low for 2 cycles -> two NOP bubbles with `fd_valid`=0, PC held, counter held; resumes on ready.
- Redirect to 32'hFFFF_FFFF then fetch -> `fd_pc`=0, `imem_addr`=0.
- Assert `reset` low mid-stream between edges -> outputs return to reset values immediately, BOOT re-entered.
